action_ctrl: RTL and testbench

ACTION_CTRL -- requirements
Module: action_ctrl

---
 rtl/action_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_action_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/action_ctrl.sv
// Action controller for a two-player fighting game.
// Decodes the held USB HID keycodes into per-player attack/dodge levels and
// sequences each player through IDLE -> ATTACK -> COOL, with hit feedback
// from the hp stage pushing a player into STUN. A game-over flag freezes
// both players in IDLE with every action output held low until Reset.

module ActionPlayer #(
  parameter int         ANIM_FRAMES = 8,
  parameter int         COOL_FRAMES = 12,
  parameter int         STUN_FRAMES = 8,
  parameter int         CNT_W       = 4,
  parameter logic [7:0] FIGHT_KEY   = 8'h09,
  parameter logic [7:0] KICK_KEY    = 8'h0A,
  parameter logic [7:0] JUMP_KEY    = 8'h1A,
  parameter logic [7:0] DODGE_KEY   = 8'h16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frameTick_i,
  input  logic [7:0] keycode0_i,
  input  logic [7:0] keycode1_i,
  input  logic [1:0] back_i,
  input  logic       winNow_i,
  input  logic       gameOver_i,
  output logic       kick_o,
  output logic       fight_o,
  output logic       jump_o,
  output logic       dodge_o,
  output logic       valid_o
);

  typedef enum logic [1:0] {IDLE, ATTACK, COOL, STUN} state_t;
  typedef enum logic [1:0] {ACT_KICK, ACT_FIGHT, ACT_JUMP} act_t;

  localparam logic [CNT_W-1:0] ANIM_C      = CNT_W'(ANIM_FRAMES);
  localparam logic [CNT_W-1:0] COOL_LAST_C = CNT_W'((COOL_FRAMES > 0) ? COOL_FRAMES - 1 : 0);
  localparam logic [CNT_W-1:0] STUN_FULL_C = CNT_W'(STUN_FRAMES);
  localparam logic [CNT_W-1:0] STUN_HALF_C = CNT_W'(STUN_FRAMES / 2);
  localparam logic [CNT_W-1:0] ONE_C       = CNT_W'(1);

  state_t           state_q, state_d;
  act_t             act_q, act_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stunPend_q, stunPend_d;
  logic [CNT_W-1:0] stunLen_q, stunLen_d;
  logic             needRelease_q, needRelease_d;
  logic [1:0]       backPrev_q;

  logic             kickHeld, fightHeld, jumpHeld, dodgeHeld;
  logic             anyAttackHeld, latchedHeld, hitEdge, active;
  logic [CNT_W-1:0] hitLen;

  // A key counts as held when it shows up on either keycode slot.
  assign kickHeld      = (keycode0_i == KICK_KEY)  || (keycode1_i == KICK_KEY);
  assign fightHeld     = (keycode0_i == FIGHT_KEY) || (keycode1_i == FIGHT_KEY);
  assign jumpHeld      = (keycode0_i == JUMP_KEY)  || (keycode1_i == JUMP_KEY);
  assign dodgeHeld     = (keycode0_i == DODGE_KEY) || (keycode1_i == DODGE_KEY);
  assign anyAttackHeld = kickHeld || fightHeld || jumpHeld;

  assign latchedHeld = (act_q == ACT_KICK)  ? kickHeld  :
                       (act_q == ACT_FIGHT) ? fightHeld : jumpHeld;

  // Only the 00 -> nonzero change of the feedback is a new hit; 11 counts as full.
  assign hitEdge = (backPrev_q == 2'b00) && (back_i != 2'b00);
  assign hitLen  = back_i[1] ? STUN_FULL_C : STUN_HALF_C;

  // Any attack key held outside IDLE must be released before it can fire again.
  assign needRelease_d = anyAttackHeld && (needRelease_q || (state_q != IDLE));

  // State, counter, latched action, pending stun and hit-edge history.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= IDLE;
      act_q         <= ACT_KICK;
      cnt_q         <= '0;
      stunPend_q    <= 1'b0;
      stunLen_q     <= '0;
      needRelease_q <= 1'b0;
      backPrev_q    <= 2'b00;
    end else begin
      state_q       <= state_d;
      act_q         <= act_d;
      cnt_q         <= cnt_d;
      stunPend_q    <= stunPend_d;
      stunLen_q     <= stunLen_d;
      needRelease_q <= needRelease_d;
      backPrev_q    <= back_i;
    end
  end

  // Next-state logic; counters only move on frame ticks and never wrap.
  always_comb begin
    state_d    = state_q;
    act_d      = act_q;
    cnt_d      = cnt_q;
    stunPend_d = stunPend_q;
    stunLen_d  = stunLen_q;
    if (winNow_i || gameOver_i) begin
      state_d    = IDLE;
      cnt_d      = '0;
      stunPend_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hitEdge) begin
            state_d = STUN;
            cnt_d   = hitLen;
          end else if (anyAttackHeld && !needRelease_q) begin
            state_d = ATTACK;
            cnt_d   = '0;
            if (kickHeld)       act_d = ACT_KICK;
            else if (fightHeld) act_d = ACT_FIGHT;
            else                act_d = ACT_JUMP;
          end
        end
        ATTACK: begin
          if (frameTick_i && (cnt_q != ANIM_C)) cnt_d = cnt_q + ONE_C;
          if (hitEdge) begin
            stunPend_d = 1'b1;
            stunLen_d  = hitLen;
          end
          if ((cnt_q == ANIM_C) && !latchedHeld) begin
            stunPend_d = 1'b0;
            if (hitEdge) begin
              state_d = STUN;
              cnt_d   = hitLen;
            end else if (stunPend_q) begin
              state_d = STUN;
              cnt_d   = stunLen_q;
            end else begin
              state_d = COOL;
              cnt_d   = '0;
            end
          end
        end
        COOL: begin
          if (hitEdge) begin
            state_d = STUN;
            cnt_d   = hitLen;
          end else if (frameTick_i) begin
            if (cnt_q >= COOL_LAST_C) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + ONE_C;
            end
          end
        end
        STUN: begin
          if (frameTick_i) begin
            if (cnt_q <= ONE_C) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q - ONE_C;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs decode straight from state so Reset clears them within the cycle.
  assign active  = (state_q == ATTACK) && !gameOver_i;
  assign kick_o  = active && (act_q == ACT_KICK);
  assign fight_o = active && (act_q == ACT_FIGHT);
  assign jump_o  = active && (act_q == ACT_JUMP);
  assign dodge_o = dodgeHeld && ((state_q == IDLE) || (state_q == STUN)) && !gameOver_i;
  assign valid_o = (state_q == IDLE) && !winNow_i && !gameOver_i;

endmodule

module action_ctrl #(
  parameter int ANIM_FRAMES = 8,
  parameter int COOL_FRAMES = 12,
  parameter int STUN_FRAMES = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic [7:0] keycode0,
  input  logic [7:0] keycode1,
  input  logic [1:0] back1,
  input  logic [1:0] back2,
  input  logic       p1win,
  input  logic       p2win,
  output logic       kick1,
  output logic       fight1,
  output logic       jump1,
  output logic       dodge1,
  output logic       valid1,
  output logic       kick2,
  output logic       fight2,
  output logic       jump2,
  output logic       dodge2,
  output logic       valid2
);

  localparam int MAX_AC = (ANIM_FRAMES > COOL_FRAMES) ? ANIM_FRAMES : COOL_FRAMES;
  localparam int MAX_F  = (MAX_AC > STUN_FRAMES) ? MAX_AC : STUN_FRAMES;
  localparam int CNT_W  = (MAX_F < 2) ? 1 : $clog2(MAX_F + 1);

  logic gameOver_q, gameOver_d, winNow;

  assign winNow     = p1win || p2win;
  assign gameOver_d = gameOver_q || winNow;

  // Game over is sticky until Reset, even if the win flags drop again.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) gameOver_q <= 1'b0;
    else       gameOver_q <= gameOver_d;
  end

  ActionPlayer #(
    .ANIM_FRAMES(ANIM_FRAMES), .COOL_FRAMES(COOL_FRAMES), .STUN_FRAMES(STUN_FRAMES),
    .CNT_W(CNT_W),
    .FIGHT_KEY(8'h09), .KICK_KEY(8'h0A), .JUMP_KEY(8'h1A), .DODGE_KEY(8'h16)
  ) player1 (
    .Clk(Clk), .Reset(Reset), .frameTick_i(frame_tick),
    .keycode0_i(keycode0), .keycode1_i(keycode1), .back_i(back1),
    .winNow_i(winNow), .gameOver_i(gameOver_q),
    .kick_o(kick1), .fight_o(fight1), .jump_o(jump1), .dodge_o(dodge1), .valid_o(valid1)
  );

  ActionPlayer #(
    .ANIM_FRAMES(ANIM_FRAMES), .COOL_FRAMES(COOL_FRAMES), .STUN_FRAMES(STUN_FRAMES),
    .CNT_W(CNT_W),
    .FIGHT_KEY(8'h0D), .KICK_KEY(8'h0E), .JUMP_KEY(8'h52), .DODGE_KEY(8'h51)
  ) player2 (
    .Clk(Clk), .Reset(Reset), .frameTick_i(frame_tick),
    .keycode0_i(keycode0), .keycode1_i(keycode1), .back_i(back2),
    .winNow_i(winNow), .gameOver_i(gameOver_q),
    .kick_o(kick2), .fight_o(fight2), .jump_o(jump2), .dodge_o(dodge2), .valid_o(valid2)
  );

endmodule

// File: tb/tb_action_ctrl.sv
// Testbench for action_ctrl: a frame-level behavioural model of both players
// is compared against the DUT on every cycle, and directed scenarios pin the
// model with hand-counted frame durations and output levels.

module tb_action_ctrl;

  localparam int ANIM = 8;
  localparam int COOL = 12;
  localparam int STUN = 8;

  localparam int M_IDLE = 0;
  localparam int M_ATK  = 1;
  localparam int M_COOL = 2;
  localparam int M_STUN = 3;
  localparam int A_KICK  = 0;
  localparam int A_FIGHT = 1;
  localparam int A_JUMP  = 2;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic [7:0] keycode0 = 8'h00;
  logic [7:0] keycode1 = 8'h00;
  logic [1:0] back1 = 2'b00;
  logic [1:0] back2 = 2'b00;
  logic       p1win = 1'b0;
  logic       p2win = 1'b0;
  logic       kick1, fight1, jump1, dodge1, valid1;
  logic       kick2, fight2, jump2, dodge2, valid2;
  logic [9:0] dutVec;

  int tests = 0;
  int fails = 0;
  int kick1Ticks = 0;
  int kick2Ticks = 0;
  int blocked1Ticks = 0;
  int blocked2Ticks = 0;

  logic [7:0] keyKick  [2] = '{8'h0A, 8'h0E};
  logic [7:0] keyFight [2] = '{8'h09, 8'h0D};
  logic [7:0] keyJump  [2] = '{8'h1A, 8'h52};
  logic [7:0] keyDodge [2] = '{8'h16, 8'h51};

  int   mMode [2];
  int   animTicks [2];
  int   coolLeft [2];
  int   stunLeft [2];
  int   pendStun [2];
  int   act [2];
  bit   mustRel [2];
  logic [1:0] prevBack [2];
  bit   gameOver;

  always #5 Clk = ~Clk;

  action_ctrl #(.ANIM_FRAMES(ANIM), .COOL_FRAMES(COOL), .STUN_FRAMES(STUN)) dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick),
    .keycode0(keycode0), .keycode1(keycode1),
    .back1(back1), .back2(back2), .p1win(p1win), .p2win(p2win),
    .kick1(kick1), .fight1(fight1), .jump1(jump1), .dodge1(dodge1), .valid1(valid1),
    .kick2(kick2), .fight2(fight2), .jump2(jump2), .dodge2(dodge2), .valid2(valid2)
  );

  assign dutVec = {kick1, fight1, jump1, dodge1, valid1, kick2, fight2, jump2, dodge2, valid2};

  function automatic bit held(input logic [7:0] code);
    return (keycode0 == code) || (keycode1 == code);
  endfunction

  task automatic resetModel();
    for (int p = 0; p < 2; p++) begin
      mMode[p] = M_IDLE; animTicks[p] = 0; coolLeft[p] = 0; stunLeft[p] = 0;
      pendStun[p] = -1; act[p] = A_KICK; mustRel[p] = 1'b0; prevBack[p] = 2'b00;
    end
    gameOver = 1'b0;
  endtask

  // One clock of the game rules for player p, in frames remaining/elapsed.
  task automatic modelStep(input int p);
    logic [1:0] b;
    bit kH, fH, jH, anyA, hit, latched;
    int len, oldMode;
    b = (p == 0) ? back1 : back2;
    kH = held(keyKick[p]); fH = held(keyFight[p]); jH = held(keyJump[p]);
    anyA = kH || fH || jH;
    hit = (prevBack[p] == 2'b00) && (b != 2'b00);
    len = b[1] ? STUN : STUN / 2;
    oldMode = mMode[p];
    if (p1win || p2win || gameOver) begin
      mMode[p] = M_IDLE;
      pendStun[p] = -1;
    end else if (oldMode == M_IDLE) begin
      if (hit) begin
        mMode[p] = M_STUN; stunLeft[p] = len;
      end else if (anyA && !mustRel[p]) begin
        mMode[p] = M_ATK; animTicks[p] = 0;
        act[p] = kH ? A_KICK : (fH ? A_FIGHT : A_JUMP);
      end
    end else if (oldMode == M_ATK) begin
      latched = (act[p] == A_KICK) ? kH : ((act[p] == A_FIGHT) ? fH : jH);
      if (hit) pendStun[p] = len;
      if (animTicks[p] >= ANIM && !latched) begin
        if (pendStun[p] >= 0) begin
          mMode[p] = M_STUN; stunLeft[p] = pendStun[p];
        end else begin
          mMode[p] = M_COOL; coolLeft[p] = COOL;
        end
        pendStun[p] = -1;
      end
      if (frame_tick) animTicks[p]++;
    end else if (oldMode == M_COOL) begin
      if (hit) begin
        mMode[p] = M_STUN; stunLeft[p] = len;
      end else if (frame_tick) begin
        coolLeft[p]--;
        if (coolLeft[p] <= 0) mMode[p] = M_IDLE;
      end
    end else begin
      if (frame_tick) begin
        stunLeft[p]--;
        if (stunLeft[p] <= 0) mMode[p] = M_IDLE;
      end
    end
    if (!anyA) mustRel[p] = 1'b0;
    else if (oldMode != M_IDLE) mustRel[p] = 1'b1;
    prevBack[p] = b;
  endtask

  function automatic logic [9:0] expectedVec();
    logic [9:0] v;
    bit atk, win;
    win = p1win || p2win;
    v = '0;
    for (int p = 0; p < 2; p++) begin
      atk = (mMode[p] == M_ATK) && !gameOver;
      v[9 - 5*p] = atk && (act[p] == A_KICK);
      v[8 - 5*p] = atk && (act[p] == A_FIGHT);
      v[7 - 5*p] = atk && (act[p] == A_JUMP);
      v[6 - 5*p] = held(keyDodge[p]) && (mMode[p] == M_IDLE || mMode[p] == M_STUN) && !gameOver;
      v[5 - 5*p] = (mMode[p] == M_IDLE) && !win && !gameOver;
    end
    return v;
  endfunction

  task automatic modelLoop();
    forever begin
      @(posedge Clk or posedge Reset);
      if (Reset) resetModel();
      else begin
        for (int p = 0; p < 2; p++) modelStep(p);
        if (p1win || p2win) gameOver = 1'b1;
      end
    end
  endtask

  task automatic compareLoop();
    logic [9:0] e;
    forever begin
      @(negedge Clk);
      e = expectedVec();
      tests++;
      if (dutVec !== e) begin
        fails++;
        $display("[TB] FAIL cycleCompare t=%0t dut=%b expected=%b", $time, dutVec, e);
      end
      if (frame_tick) begin
        if (kick1) kick1Ticks++;
        if (kick2) kick2Ticks++;
        if (!valid1 && !kick1 && !fight1 && !jump1) blocked1Ticks++;
        if (!valid2 && !kick2 && !fight2 && !jump2) blocked2Ticks++;
      end
    end
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] k0, input logic [7:0] k1);
    keycode0 = k0;
    keycode1 = k1;
  endtask

  task automatic step(input logic tick);
    @(posedge Clk);
    #1;
    frame_tick = tick;
  endtask

  task automatic runFrames(input int n);
    repeat (n) begin
      step(1'b1);
      repeat (3) step(1'b0);
    end
  endtask

  task automatic clearCounts();
    kick1Ticks = 0; kick2Ticks = 0; blocked1Ticks = 0; blocked2Ticks = 0;
  endtask

  task automatic pulseReset();
    Reset = 1'b1;
    step(1'b0);
    Reset = 1'b0;
    step(1'b0);
  endtask

  initial begin
    resetModel();
    fork
      modelLoop();
      compareLoop();
    join_none

    repeat (3) step(1'b0);
    Reset = 1'b0;
    step(1'b0);
    checkOutput("resetState", int'(dutVec), 10'b0000100001);

    // Kick held 3 frames: 8 frames of kick, 12 frames of cooldown, then valid.
    clearCounts();
    applyStimulus(8'h0A, 8'h00);
    runFrames(3);
    applyStimulus(8'h00, 8'h00);
    runFrames(22);
    checkOutput("kickFrames", kick1Ticks, 8);
    checkOutput("coolFrames", blocked1Ticks, 12);
    checkOutput("validAfterCool", int'(valid1), 1);

    // Kick and fight together: only kick.
    applyStimulus(8'h0A, 8'h09);
    runFrames(1);
    checkOutput("priorityKick", int'(kick1), 1);
    checkOutput("priorityFight", int'(fight1), 0);
    applyStimulus(8'h00, 8'h00);
    runFrames(24);

    // Full and dodged hits on an idle P2.
    clearCounts();
    back2 = 2'b10;
    runFrames(10);
    checkOutput("stunFull", blocked2Ticks, 8);
    checkOutput("validAfterStun", int'(valid2), 1);
    back2 = 2'b00;
    runFrames(1);
    clearCounts();
    back2 = 2'b01;
    runFrames(6);
    checkOutput("stunHalf", blocked2Ticks, 4);
    back2 = 2'b00;
    runFrames(1);

    // Hit during an attack: stun replaces cooldown.
    applyStimulus(8'h0A, 8'h00);
    runFrames(2);
    back1 = 2'b10;
    runFrames(1);
    checkOutput("attackNotInterrupted", int'(kick1), 1);
    back1 = 2'b00;
    runFrames(7);
    clearCounts();
    applyStimulus(8'h00, 8'h00);
    runFrames(12);
    checkOutput("stunInsteadOfCool", blocked1Ticks, 8);

    // Dodge: allowed in IDLE, suppressed in ATTACK.
    applyStimulus(8'h00, 8'h16);
    #1;
    checkOutput("dodgeIdle", int'(dodge1), 1);
    applyStimulus(8'h1A, 8'h16);
    runFrames(1);
    checkOutput("jumpLatched", int'(jump1), 1);
    checkOutput("dodgeInAttack", int'(dodge1), 0);
    applyStimulus(8'h00, 8'h00);
    runFrames(24);

    // Key held through cooldown must be re-pressed.
    applyStimulus(8'h0E, 8'h00);
    runFrames(9);
    applyStimulus(8'h00, 8'h00);
    runFrames(2);
    applyStimulus(8'h0E, 8'h00);
    clearCounts();
    runFrames(15);
    checkOutput("heldNoRearm", kick2Ticks, 0);
    checkOutput("heldValid", int'(valid2), 1);
    applyStimulus(8'h00, 8'h00);
    step(1'b0);
    applyStimulus(8'h0E, 8'h00);
    runFrames(1);
    checkOutput("rearmKick", int'(kick2), 1);
    applyStimulus(8'h00, 8'h00);
    runFrames(24);

    // Game over during a P2 attack.
    applyStimulus(8'h00, 8'h0D);
    runFrames(2);
    checkOutput("fight2Active", int'(fight2), 1);
    p1win = 1'b1;
    step(1'b0);
    checkOutput("gameOverOutputs", int'(dutVec), 0);
    p1win = 1'b0;
    applyStimulus(8'h0A, 8'h0D);
    runFrames(3);
    checkOutput("gameOverHeld", int'(dutVec), 0);
    applyStimulus(8'h00, 8'h00);
    pulseReset();
    checkOutput("afterGameOverReset", int'(dutVec), 10'b0000100001);

    // Reset in the middle of an attack.
    applyStimulus(8'h09, 8'h00);
    runFrames(2);
    checkOutput("fight1Active", int'(fight1), 1);
    Reset = 1'b1;
    #1;
    checkOutput("resetDropsAttack", int'(fight1), 0);
    step(1'b0);
    applyStimulus(8'h00, 8'h00);
    Reset = 1'b0;
    #1;
    checkOutput("validAfterReset", int'({valid1, valid2}), 3);
    runFrames(2);
    checkOutput("noCoolAfterReset", int'(valid1), 1);

    step(1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
